// File: rtl/online_digit_packer_pkg.sv
// Shared definitions for the online result buffer packer and its future read-side unpacker.
package online_digit_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_e;

  function automatic int digits_per_word(input int data_width, input int digit_width);
    return data_width / digit_width;
  endfunction

  localparam int DIGITS_PER_WORD = digits_per_word(64, 2);

endpackage

// File: rtl/online_digit_packer_shift.sv
// Shift register plus digit counter: assembles MSD-first digits into one left-aligned word.
module digit_shift_word
  import online_digit_packer_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int DIGIT_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   sync_clear_i,
  input  logic                   clear_i,
  input  logic                   shift_i,
  input  logic [DIGIT_WIDTH-1:0] digit_i,
  output logic                   word_full_o,
  output logic                   pending_o,
  output logic [DATA_WIDTH-1:0]  word_o
);

  localparam int N  = digits_per_word(DATA_WIDTH, DIGIT_WIDTH);
  localparam int CW = $clog2(N) + 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           pad_bits;

  always_comb begin
    shifted     = (shift_q << DIGIT_WIDTH) | DATA_WIDTH'(digit_i);
    word_full_o = shift_i && (cnt_q == CW'(N - 1));
    pending_o   = (cnt_q != '0);
    // Partial word: push the collected digits up to the MSB end, zeros below.
    pad_bits    = 32'(DIGIT_WIDTH) * (32'(N) - 32'(cnt_q));
    word_o      = word_full_o ? shifted : (shift_q << pad_bits);
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = shifted;
      cnt_d   = word_full_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/online_digit_packer.sv
// Write-side packer: groups online digits into RAM words and drives the buffer RAM write port.
module online_digit_packer
  import online_digit_packer_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 7,
  parameter int DIGIT_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  sync_clear,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  digit_valid,
  input  logic [DIGIT_WIDTH-1:0] digit_in,
  input  logic                  last_digit,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  pack_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic                  accept, clear_word, write_req, word_full, pending;
  logic [DATA_WIDTH-1:0] word;

  assign accept     = (state_q == ST_PACK) && digit_valid;
  assign clear_word = ((state_q == ST_IDLE) && start) || (state_q == ST_FLUSH);
  assign write_req  = ((state_q == ST_PACK) && word_full) || ((state_q == ST_FLUSH) && pending);

  digit_shift_word #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIGIT_WIDTH(DIGIT_WIDTH)
  ) u_shift (
    .clk         (clk),
    .sync_clear_i(sync_clear),
    .clear_i     (clear_word),
    .shift_i     (accept),
    .digit_i     (digit_in),
    .word_full_o (word_full),
    .pending_o   (pending),
    .word_o      (word)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wcount_d = wcount_q;
    ovf_d    = ovf_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_PACK;
        addr_d   = base_addr;
        wcount_d = '0;
        ovf_d    = 1'b0;
      end
      ST_PACK:  if (last_digit) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Once the buffer has been filled, further words are dropped rather than overwriting.
    if (write_req) begin
      if (wcount_q == MAX_WORDS) begin
        ovf_d = 1'b1;
      end else begin
        we_d     = 1'b1;
        wdata_d  = word;
        waddr_d  = addr_q;
        addr_d   = addr_q + ADDR_WIDTH'(1);
        wcount_d = wcount_q + (ADDR_WIDTH+1)'(1);
      end
    end
    busy_d = (state_d == ST_PACK) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (sync_clear) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wcount_q <= '0;
      ovf_q    <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wcount_q <= wcount_d;
      ovf_q    <= ovf_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ram_data       = wdata_q;
  assign ram_write_addr = waddr_q;
  assign ram_we         = we_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign word_count     = wcount_q;
  assign overflow       = ovf_q;

endmodule
